// File: rtl/cmp_checker_mc.sv
// Read-data checker: queues expected-read descriptors, generates per-beat patterns,
// compares returned beats under byte enable and reports errors to the CSR block.
module cmp_checker_mc #(
  parameter int DATA_W     = 128,
  parameter int ADDR_W     = 32,
  parameter int BURST_W    = 11,
  parameter int FIFO_DEPTH = 8,
  parameter int ERR_CNT_W  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 test_start_i,
  input  logic                 cmp_en_i,
  output logic                 cmp_ready_o,
  input  logic [ADDR_W-1:0]    cmp_addr_i,
  input  logic [BURST_W-1:0]   cmp_burst_i,
  input  logic [1:0]           cmp_mode_i,
  input  logic [31:0]          cmp_seed_i,
  input  logic [DATA_W/8-1:0]  cmp_byteen_i,
  input  logic                 readdatavalid_i,
  input  logic [DATA_W-1:0]    readdata_i,
  output logic                 cmp_error_o,
  output logic                 unexp_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o,
  output logic [ADDR_W-1:0]    err_addr_o,
  output logic [DATA_W-1:0]    err_data_o,
  output logic                 cmp_busy_o
);

  localparam int BE_W  = DATA_W / 8;
  localparam int REP   = DATA_W / 32;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [31:0] TAPS = 32'h8020_0003;

  typedef enum logic [1:0] {
    M_FIXED = 2'd0,
    M_INC   = 2'd1,
    M_LFSR  = 2'd2,
    M_ADDR  = 2'd3
  } mode_e;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [BURST_W-1:0] burst;
    logic [1:0]         mode;
    logic [31:0]        seed;
    logic [BE_W-1:0]    byteen;
  } desc_t;

  desc_t              fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  desc_t              head;
  desc_t              push_desc;

  logic [BURST_W-1:0] beat_idx_q;
  logic [BURST_W-1:0] burst_eff;
  logic               last_beat;
  logic               beat_take;
  logic [31:0]        lfsr_q;
  logic [31:0]        lfsr_cur;
  logic [31:0]        lfsr_nxt;
  logic [ADDR_W-1:0]  beat_addr;
  logic [31:0]        exp_word;

  logic               s1_valid_q;
  logic               s1_unexp_q;
  logic [DATA_W-1:0]  s1_data_q;
  logic [DATA_W-1:0]  s1_exp_q;
  logic [BE_W-1:0]    s1_be_q;
  logic [ADDR_W-1:0]  s1_addr_q;
  logic [BE_W-1:0]    byte_bad;
  logic               mismatch;
  logic               err_hit;

  logic               cmp_error_q;
  logic               unexp_q;
  logic [ERR_CNT_W-1:0] err_cnt_q;
  logic [ADDR_W-1:0]  err_addr_q;
  logic [DATA_W-1:0]  err_data_q;

  assign full        = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty       = (count_q == '0);
  assign cmp_ready_o = !full;
  assign push        = cmp_en_i && !full && !test_start_i;
  assign beat_take   = readdatavalid_i && !empty && !test_start_i;
  assign pop         = beat_take && last_beat;
  assign head        = fifo_q[rd_ptr_q];

  assign push_desc = '{
    addr:   cmp_addr_i,
    burst:  cmp_burst_i,
    mode:   cmp_mode_i,
    seed:   cmp_seed_i,
    byteen: cmp_byteen_i
  };

  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q] <= push_desc;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (test_start_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (!push && pop) count_q <= count_q - 1'b1;
    end
  end

  // A zero burst count is a one-beat burst.
  assign burst_eff = (head.burst == '0) ? BURST_W'(1) : head.burst;
  assign last_beat = (beat_idx_q == burst_eff - 1'b1);
  assign beat_addr = head.addr + ADDR_W'(beat_idx_q);

  assign lfsr_cur = (beat_idx_q != '0)   ? lfsr_q :
                    (head.seed == '0)    ? 32'd1  : head.seed;
  assign lfsr_nxt = (lfsr_cur >> 1) ^ (lfsr_cur[0] ? TAPS : 32'd0);

  always_comb begin
    exp_word = head.seed;
    unique case (mode_e'(head.mode))
      M_FIXED: exp_word = head.seed;
      M_INC:   exp_word = head.seed + 32'(beat_idx_q);
      M_LFSR:  exp_word = lfsr_cur;
      M_ADDR:  exp_word = 32'(beat_addr);
      default: exp_word = head.seed;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      beat_idx_q <= '0;
      lfsr_q     <= '0;
    end else if (test_start_i) begin
      beat_idx_q <= '0;
      lfsr_q     <= '0;
    end else if (beat_take) begin
      beat_idx_q <= last_beat ? '0 : beat_idx_q + 1'b1;
      lfsr_q     <= lfsr_nxt;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s1_unexp_q <= 1'b0;
      s1_data_q  <= '0;
      s1_exp_q   <= '0;
      s1_be_q    <= '0;
      s1_addr_q  <= '0;
    end else if (test_start_i) begin
      s1_valid_q <= 1'b0;
      s1_unexp_q <= 1'b0;
    end else begin
      s1_valid_q <= readdatavalid_i;
      if (readdatavalid_i) begin
        s1_unexp_q <= empty;
        s1_data_q  <= readdata_i;
        s1_exp_q   <= {REP{exp_word}};
        s1_be_q    <= head.byteen;
        s1_addr_q  <= beat_addr;
      end
    end
  end

  always_comb begin
    byte_bad = '0;
    for (int i = 0; i < BE_W; i++) begin
      byte_bad[i] = s1_be_q[i] &&
                    (s1_data_q[8*i +: 8] != s1_exp_q[8*i +: 8]);
    end
  end

  assign mismatch = s1_valid_q && !s1_unexp_q && (|byte_bad);
  assign err_hit  = mismatch || (s1_valid_q && s1_unexp_q);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cmp_error_q <= 1'b0;
      unexp_q     <= 1'b0;
      err_cnt_q   <= '0;
      err_addr_q  <= '0;
      err_data_q  <= '0;
    end else if (test_start_i) begin
      cmp_error_q <= 1'b0;
      unexp_q     <= 1'b0;
      err_cnt_q   <= '0;
      err_addr_q  <= '0;
      err_data_q  <= '0;
    end else begin
      if (mismatch) cmp_error_q <= 1'b1;
      if (s1_valid_q && s1_unexp_q) unexp_q <= 1'b1;
      if (err_hit && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + 1'b1;
      // The sticky error flag doubles as the "already captured" marker.
      if (mismatch && !cmp_error_q) begin
        err_addr_q <= s1_addr_q;
        err_data_q <= s1_data_q;
      end
    end
  end

  assign cmp_error_o = cmp_error_q;
  assign unexp_o     = unexp_q;
  assign err_cnt_o   = err_cnt_q;
  assign err_addr_o  = err_addr_q;
  assign err_data_o  = err_data_q;
  assign cmp_busy_o  = !empty || (beat_idx_q != '0) || s1_valid_q;

endmodule

// File: doc/cmp_checker_mc.md
Name: cmp_checker_mc

Overview:
Parametrised successor to the single-pattern compare stage of the memory checker. It buffers expected-read descriptors from the transmitter in a descriptor FIFO and generates expected data per beat in one of four pattern modes. It compares each returned beat of the memory read-data stream under byte-enable, and reports a sticky error, a saturating error count, first-error capture and unexpected-data detection. It sits in the memory clock domain, between the transmitter (descriptor source) and the memory read-data return path; its results feed the CSR block.

Parameters:
DATA_W, 128, memory data width in bits; multiple of 32.
ADDR_W, 32, word address width.
BURST_W, 11, burst count width.
FIFO_DEPTH, 8, descriptor FIFO depth; power of two, >= 2.
ERR_CNT_W, 16, error counter width.

Ports:
clk_i  in  1  memory-domain clock
rst_i  in  1  asynchronous active-high reset
test_start_i  in  1  one-cycle pulse; clears all state
cmp_en_i  in  1  descriptor push strobe
cmp_ready_o  out  1  descriptor FIFO not full
cmp_addr_i  in  ADDR_W  word address of first beat
cmp_burst_i  in  BURST_W  beats in burst; 0 treated as 1
cmp_mode_i  in  2  pattern: 0 FIXED, 1 INC, 2 LFSR, 3 ADDR
cmp_seed_i  in  32  pattern seed
cmp_byteen_i  in  DATA_W/8  byte enables applied to every beat of the descriptor
readdatavalid_i  in  1  memory read beat valid
readdata_i  in  DATA_W  memory read beat
cmp_error_o  out  1  sticky: at least one mismatching beat
unexp_o  out  1  sticky: beat received with no descriptor pending
err_cnt_o  out  ERR_CNT_W  mismatching beats plus unexpected beats; saturates at all-ones
err_addr_o  out  ADDR_W  address of first mismatching beat
err_data_o  out  DATA_W  read data of first mismatching beat
cmp_busy_o  out  1  FIFO non-empty, or burst in progress, or pipeline valid

Behaviour:
- Interface: one clock, clk_i. Reset rst_i is asynchronous and active-high.
- Reset values: all outputs 0, except cmp_ready_o = 1. FIFO empty, pipeline invalid.
- Descriptor push:
  - A push occurs when cmp_en_i && cmp_ready_o.
  - cmp_ready_o = !full, taken from the registered FIFO count. A push on a cycle where the FIFO is full is dropped, even if a pop occurs on the same cycle.
  - Simultaneous push and pop on a non-full FIFO: count unchanged.
- Beat tracking:
  - The head descriptor is active. beat_idx counts from 0 to burst-1.
  - On readdatavalid_i, beat_idx increments. On the last beat the head is popped and beat_idx returns to 0.
  - A readdatavalid_i arriving the cycle after a pop uses the next descriptor with no bubble.
- Expected data for beat k, with each 32-bit word replicated DATA_W/32 times:
  - FIXED: seed.
  - INC: seed + k, mod 2^32.
  - ADDR: addr + k, truncated or zero-extended to 32 bits.
  - LFSR: 32-bit Galois LFSR, taps 0x80200003. State = seed at k=0 (seed 0 is replaced by 1), advanced once per beat.
- Pipeline:
  - Stage 1 registers readdata, expected data, byteen, beat address (addr + k) and the unexpected flag.
  - Stage 2 compares enabled bytes only. A beat is a mismatch if any enabled byte differs; byteen all-zero never mismatches.
  - A mismatch on the input beat in cycle N is visible on cmp_error_o / err_cnt_o at cycle N+2.
- First-error capture: err_addr_o and err_data_o load on the first mismatch after reset or test_start_i only. Later mismatches leave them unchanged.
- Unexpected data:
  - readdatavalid_i with the FIFO empty sets unexp_o at N+2 and increments err_cnt_o.
  - It does not set cmp_error_o and does not load the capture registers.
- err_cnt_o:
  - Increments by 1 per erroneous beat and holds at 2^ERR_CNT_W-1.
  - Mismatches still set cmp_error_o after saturation.
- test_start_i:
  - Synchronously clears the FIFO, beat_idx, pipeline, sticky flags, counter and capture registers.
  - A push on the same cycle is dropped. Beats in flight on that cycle are discarded.
  - Assertion mid-burst abandons the burst.
- cmp_busy_o falls on the cycle after the last beat leaves stage 2.

Test Plan:
- FIXED seed 0xA5A5A5A5, burst 4, byteen all-ones, matching data -> cmp_error_o=0, err_cnt_o=0, cmp_busy_o drops 2 cycles after last beat.
- INC seed 0x10, addr 0x100, burst 8, beat 5 word0 corrupted to 0x14 -> cmp_error_o=1 at N+2, err_cnt_o=1, err_addr_o=0x105, err_data_o=corrupted beat; later mismatch on beat 7 -> err_cnt_o=2, capture unchanged.
- LFSR seed 0, burst 3 -> expected words 1, then the next two LFSR states; byteen=0x0001 with upper bytes corrupted -> no error.
- Push 9 descriptors back-to-back with FIFO_DEPTH=8 and no read data -> cmp_ready_o=0 after 8, 9th dropped; return 8 bursts back-to-back with no gaps -> all compared, no error.
- readdatavalid_i with FIFO empty -> unexp_o=1, err_cnt_o=1, cmp_error_o=0; ERR_CNT_W=4 with 20 mismatches -> err_cnt_o=15.
- test_start_i mid-burst (beat 2 of 6) with a simultaneous push -> all outputs cleared, FIFO empty; next beats flag unexp_o.
